// File: rtl/cc_unit.sv
// Condition-code unit: derives N/Z/C/V from an ALU operation, keeps the flag register,
// evaluates condition codes with same-cycle forwarding and tracks sticky overflow events.
module cc_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             set_flags,
    input  logic             cond_valid,
    input  logic [3:0]       cond_sel,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_sticky,
    output logic [3:0]       flags,
    output logic             cond_out_valid,
    output logic             cond_true,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [3:0]       OP_ADD  = 4'b1110;
    localparam logic [3:0]       OP_SUB  = 4'b1101;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] sum_lo;
    logic             same_sign;
    logic             res_flip;
    logic             n_nx, z_nx, c_nx, v_nx;
    logic [3:0]       nxt_flags;
    logic [3:0]       eff_flags;
    logic             cond_eval;
    logic             ovf_event;

    always_comb begin
        sum_lo    = a + b;
        same_sign = (a[WIDTH-1] == b[WIDTH-1]);
        res_flip  = (alu_out[WIDTH-1] != a[WIDTH-1]);
        n_nx      = alu_out[WIDTH-1];
        z_nx      = (alu_out == '0);
        c_nx      = 1'b0;
        v_nx      = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                // a wrapped sum smaller than an operand means the carry-out was set
                c_nx = (sum_lo < a);
                v_nx = same_sign & res_flip;
            end
            OP_SUB: begin
                c_nx = (a >= b);
                v_nx = ~same_sign & res_flip;
            end
            default: ;
        endcase
        nxt_flags = {n_nx, z_nx, c_nx, v_nx};
        eff_flags = set_flags ? nxt_flags : flags;
        ovf_event = set_flags & ~stall & v_nx;
    end

    // eff_flags = {N, Z, C, V}
    always_comb begin
        cond_eval = 1'b0;
        case (cond_sel)
            4'd0:  cond_eval = eff_flags[2];
            4'd1:  cond_eval = ~eff_flags[2];
            4'd2:  cond_eval = eff_flags[1];
            4'd3:  cond_eval = ~eff_flags[1];
            4'd4:  cond_eval = eff_flags[3];
            4'd5:  cond_eval = ~eff_flags[3];
            4'd6:  cond_eval = eff_flags[0];
            4'd7:  cond_eval = ~eff_flags[0];
            4'd8:  cond_eval = eff_flags[1] & ~eff_flags[2];
            4'd9:  cond_eval = ~eff_flags[1] | eff_flags[2];
            4'd10: cond_eval = (eff_flags[3] == eff_flags[0]);
            4'd11: cond_eval = (eff_flags[3] != eff_flags[0]);
            4'd12: cond_eval = ~eff_flags[2] & (eff_flags[3] == eff_flags[0]);
            4'd13: cond_eval = eff_flags[2] | (eff_flags[3] != eff_flags[0]);
            4'd14: cond_eval = 1'b1;
            4'd15: cond_eval = 1'b0;
            default: cond_eval = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags          <= 4'b0000;
            cond_out_valid <= 1'b0;
            cond_true      <= 1'b0;
            sticky_v       <= 1'b0;
            ovf_count      <= '0;
        end else begin
            // flush overrides stall only for the evaluation pipeline, never for flag state
            if (flush) begin
                cond_out_valid <= 1'b0;
            end else if (!stall) begin
                cond_out_valid <= cond_valid;
                if (cond_valid) begin
                    cond_true <= cond_eval;
                end
            end

            if (!stall && set_flags) begin
                flags <= nxt_flags;
            end

            if (ovf_event) begin
                sticky_v <= 1'b1;
                if (clr_sticky) begin
                    ovf_count <= CNT_W'(1);
                end else if (ovf_count != CNT_MAX) begin
                    ovf_count <= ovf_count + CNT_W'(1);
                end
            end else if (!stall && clr_sticky) begin
                sticky_v  <= 1'b0;
                ovf_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cc_unit.sv
// Bench for cc_unit: an arithmetic reference model checked every cycle, plus literal
// expectations on directed scenarios (reset, overflow, forwarding, stall/flush, saturation).
module tb_cc_unit;
    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    alu_ctrl = 4'd0;
    logic [W-1:0]  a = '0, b = '0, alu_out = '0;
    logic          set_flags = 1'b0, cond_valid = 1'b0;
    logic [3:0]    cond_sel = 4'd0;
    logic          stall = 1'b0, flush = 1'b0, clr_sticky = 1'b0;
    logic [3:0]    flags;
    logic          cond_out_valid, cond_true, sticky_v;
    logic [CW-1:0] ovf_count;

    always #5 clk = ~clk;

    cc_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .a(a), .b(b), .alu_out(alu_out),
        .set_flags(set_flags), .cond_valid(cond_valid), .cond_sel(cond_sel),
        .stall(stall), .flush(flush), .clr_sticky(clr_sticky),
        .flags(flags), .cond_out_valid(cond_out_valid), .cond_true(cond_true),
        .sticky_v(sticky_v), .ovf_count(ovf_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags from true integer arithmetic: V is signed overflow, C is unsigned carry / no-borrow.
    function automatic logic [3:0] ref_flags(input logic [3:0] ctrl, input logic [W-1:0] fa,
                                             input logic [W-1:0] fb, input logic [W-1:0] res);
        longint unsigned ua = fa;
        longint unsigned ub = fb;
        longint sa = longint'($signed(fa));
        longint sb = longint'($signed(fb));
        longint s;
        logic c = 1'b0, v = 1'b0;
        if (ctrl == 4'b1110) begin
            c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (ctrl == 4'b1101) begin
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {res[W-1], res == '0, c, v};
    endfunction

    // Odd codes are the negation of the even code below them.
    function automatic logic ref_cond(input logic [3:0] sel, input logic [3:0] f);
        logic n = f[3], z = f[2], c = f[1], v = f[0];
        logic base;
        case (sel[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ sel[0];
    endfunction

    logic [3:0] m_flags = 4'd0;
    logic       m_cov = 1'b0, m_ct = 1'b0, m_sv = 1'b0;
    int         m_cnt = 0;
    bit         m_ok = 1'b0;

    always @(posedge clk) begin : model
        logic [3:0] nx, eff;
        logic ev, clr;
        nx  = ref_flags(alu_ctrl, a, b, alu_out);
        eff = set_flags ? nx : m_flags;
        ev  = !stall && set_flags && nx[0];
        clr = !stall && clr_sticky;
        if (rst) begin
            m_flags <= 4'd0; m_cov <= 1'b0; m_ct <= 1'b0; m_sv <= 1'b0; m_cnt <= 0;
            m_ok <= 1'b1;
        end else begin
            if (flush) m_cov <= 1'b0;
            else if (!stall) begin
                m_cov <= cond_valid;
                if (cond_valid) m_ct <= ref_cond(cond_sel, eff);
            end
            if (!stall && set_flags) m_flags <= nx;
            if (ev) begin
                m_sv  <= 1'b1;
                m_cnt <= clr ? 1 : ((m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt);
            end else if (clr) begin
                m_sv  <= 1'b0;
                m_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("mdl_flags", 32'(flags), 32'(m_flags));
            chk("mdl_cov", 32'(cond_out_valid), 32'(m_cov));
            chk("mdl_ct", 32'(cond_true), 32'(m_ct));
            chk("mdl_sticky", 32'(sticky_v), 32'(m_sv));
            chk("mdl_cnt", 32'(ovf_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; set_flags = 0; cond_valid = 0; stall = 0; flush = 0; clr_sticky = 0;
    endtask

    task automatic op(input logic [3:0] ctrl, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic [W-1:0] other_res);
        alu_ctrl = ctrl; a = xa; b = xb;
        if (ctrl == 4'b1110)      alu_out = xa + xb;
        else if (ctrl == 4'b1101) alu_out = xa - xb;
        else                      alu_out = other_res;
    endtask

    localparam logic [3:0] ADD = 4'b1110, SUB = 4'b1101, LOG = 4'b0000;

    logic [3:0]   v_ctrl [7] = '{ADD, SUB, SUB, LOG, ADD, SUB, LOG};
    logic [W-1:0] v_a    [7] = '{32'h7FFFFFFF, 32'd3, 32'd5, 32'h1234, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] v_b    [7] = '{32'd1, 32'd5, 32'd3, 32'h5678, 32'd1, 32'd1, 32'd1};
    logic [W-1:0] v_res  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80000000};
    logic [3:0]   v_exp  [7] = '{4'b1001, 4'b1000, 4'b0010, 4'b0100, 4'b0110, 4'b0011, 4'b1000};

    initial begin
        idle();
        // reset wins over stall and set_flags
        rst = 1; stall = 1; set_flags = 1; op(ADD, 32'h7FFFFFFF, 32'd1, '0);
        step();
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_cov", 32'(cond_out_valid), 32'h0);
        chk("rst_ct", 32'(cond_true), 32'h0);
        chk("rst_sticky", 32'(sticky_v), 32'h0);
        chk("rst_cnt", 32'(ovf_count), 32'h0);

        idle(); set_flags = 1; op(ADD, 32'h7FFFFFFF, 32'd1, '0);
        step();
        chk("addovf_flags", 32'(flags), 32'b1001);
        chk("addovf_sticky", 32'(sticky_v), 32'h1);
        chk("addovf_cnt", 32'(ovf_count), 32'h1);

        idle(); set_flags = 1; cond_valid = 1; cond_sel = 4'd0; op(SUB, 32'd5, 32'd5, '0);
        step();
        chk("fwd_flags", 32'(flags), 32'b0110);
        chk("fwd_cov", 32'(cond_out_valid), 32'h1);
        chk("fwd_eq", 32'(cond_true), 32'h1);
        cond_sel = 4'd8;
        step();
        chk("fwd_hi", 32'(cond_true), 32'h0);
        idle();
        step();
        chk("idle_cov", 32'(cond_out_valid), 32'h0);
        chk("idle_ct_hold", 32'(cond_true), 32'h0);

        cond_valid = 1; cond_sel = 4'd14;
        step();
        chk("al_ct", 32'(cond_true), 32'h1);
        stall = 1; set_flags = 1; cond_sel = 4'd15; op(ADD, 32'd1, 32'd1, '0);
        step();
        chk("stall_flags", 32'(flags), 32'b0110);
        chk("stall_cov", 32'(cond_out_valid), 32'h1);
        chk("stall_ct", 32'(cond_true), 32'h1);
        flush = 1;
        step();
        chk("flush_stall_cov", 32'(cond_out_valid), 32'h0);
        idle(); cond_valid = 1; cond_sel = 4'd14;
        step();
        flush = 1;
        step();
        chk("flush_cov", 32'(cond_out_valid), 32'h0);

        idle(); clr_sticky = 1; stall = 1;
        step();
        chk("clr_stalled", 32'(sticky_v), 32'h1);
        stall = 0;
        step();
        chk("clr_sticky", 32'(sticky_v), 32'h0);
        chk("clr_cnt", 32'(ovf_count), 32'h0);

        // every condition code against several flag patterns, forwarded and registered
        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < 16; s++) begin
                idle(); op(v_ctrl[i], v_a[i], v_b[i], v_res[i]);
                set_flags = 1; cond_valid = 1; cond_sel = 4'(s);
                step();
                if (s == 0) chk("vec_flags", 32'(flags), 32'(v_exp[i]));
                set_flags = 0; op(LOG, '0, '0, 32'h1);
                step();
            end
        end

        idle(); clr_sticky = 1;
        step();
        idle(); set_flags = 1; op(ADD, 32'h7FFFFFFF, 32'd1, '0);
        repeat (260) step();
        chk("sat_cnt", 32'(ovf_count), 32'd255);
        chk("sat_sticky", 32'(sticky_v), 32'h1);
        clr_sticky = 1;
        step();
        chk("clr_ovf_cnt", 32'(ovf_count), 32'd1);
        chk("clr_ovf_sticky", 32'(sticky_v), 32'h1);

        idle(); cond_valid = 1; cond_sel = 4'd14;
        step();
        rst = 1;
        step();
        chk("midrst_cov", 32'(cond_out_valid), 32'h0);
        idle();
        step();
        chk("postrst_cov", 32'(cond_out_valid), 32'h0);
        chk("postrst_cnt", 32'(ovf_count), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cc_unit.md
CC_UNIT -- requirements
Module: cc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 8, overflow event counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port alu_ctrl  input  4  ALU opcode: 4'b1110 = add, 4'b1101 = subtract, all other values = non-arithmetic.
REQ-006 SHALL have port a  input  WIDTH  ALU operand A.
REQ-007 SHALL have port b  input  WIDTH  ALU operand B.
REQ-008 SHALL have port alu_out  input  WIDTH  ALU result for the same operation.
REQ-009 SHALL have port set_flags  input  1  request to update the flag register this cycle.
REQ-010 SHALL have port cond_valid  input  1  condition evaluation request.
REQ-011 SHALL have port cond_sel  input  4  condition code to evaluate (table in REQ-020).
REQ-012 SHALL have port stall  input  1  freeze all state.
REQ-013 SHALL have port flush  input  1  discard any pending or captured evaluation.
REQ-014 SHALL have port clr_sticky  input  1  clear the sticky overflow bit and the event counter.
REQ-015 SHALL have port flags  output  4  registered {N,Z,C,V}.
REQ-016 SHALL have port cond_out_valid  output  1  registered evaluation-valid.
REQ-017 SHALL have port cond_true  output  1  registered evaluation result.
REQ-018 SHALL have port sticky_v  output  1  registered sticky overflow.
REQ-019 SHALL have port ovf_count  output  CNT_W  registered saturating overflow event count.

Function
REQ-020 SHALL use the following cond_sel encoding:
- 0 EQ: Z
- 1 NE: ~Z
- 2 HS: C
- 3 LO: ~C
- 4 MI: N
- 5 PL: ~N
- 6 VS: V
- 7 VC: ~V
- 8 HI: C&~Z
- 9 LS: ~C|Z
- 10 GE: N==V
- 11 LT: N!=V
- 12 GT: ~Z&(N==V)
- 13 LE: Z|(N!=V)
- 14 AL: 1
- 15 NV: 0
REQ-021 SHALL compute the next flag values from the current inputs as follows:
- N = alu_out[WIDTH-1]
- Z = (alu_out == 0)
REQ-022 SHALL compute C and V for add as follows:
- C = carry-out of the WIDTH+1-bit sum a+b
- V = operand sign bits equal and alu_out sign bit different from them
REQ-023 SHALL compute C and V for subtract as follows:
- C = no-borrow, i.e. a >= b unsigned
- V = operand sign bits different and alu_out sign bit different from a's
REQ-024 SHALL clear C and V to 0 for non-arithmetic alu_ctrl.
REQ-025 SHALL load flags with the next flag values on a cycle with set_flags=1 and stall=0; otherwise flags SHALL hold.
REQ-026 SHALL capture an evaluation on a cycle with cond_valid=1, stall=0, flush=0:
- next cycle cond_out_valid=1
- cond_true = condition of cond_sel evaluated against the effective flags
- latency exactly 1 cycle
REQ-027 SHALL forward: the effective flags are the next flag values when set_flags=1 in the same cycle, else the registered flags.
REQ-028 SHALL, when stall=0, flush=0 and cond_valid=0, drive cond_out_valid to 0 in the next cycle; cond_true SHALL hold its last value.
REQ-029 SHALL, while stall=1, hold every register unchanged; set_flags, cond_valid and clr_sticky requests in that cycle are dropped, and the requester re-presents them.
REQ-030 SHALL give priority rst > flush > stall.
REQ-031 SHALL, on flush=1, set cond_out_valid=0 next cycle, even when stall=1 or cond_valid=1.
REQ-032 SHALL leave flags, sticky_v and ovf_count unaffected by flush; a set_flags in a flush cycle with stall=0 still updates them.
REQ-033 SHALL define an overflow event as a flag load (REQ-025) with next V=1.
REQ-034 SHALL, on an overflow event, set sticky_v=1 and increment ovf_count by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-035 SHALL, on clr_sticky=1 with stall=0, clear sticky_v and ovf_count.
REQ-036 SHALL, when clr_sticky and an overflow event coincide, produce sticky_v=1 and ovf_count=1.

Reset
REQ-037 SHALL, on a clock edge with rst=1, set the following, regardless of all other inputs including stall:
- flags=4'b0000
- cond_out_valid=0
- cond_true=0
- sticky_v=0
- ovf_count=0
REQ-038 SHALL, when rst asserts mid-evaluation, discard the evaluation, with no cond_out_valid pulse after reset.

Verification
REQ-039 SHALL cover reset: assert rst for 1 cycle with stall=1 and set_flags=1 -> flags=0000, cond_out_valid=0, sticky_v=0, ovf_count=0.
REQ-040 SHALL cover add overflow: add, a=32'h7FFFFFFF, b=32'h1, alu_out=32'h80000000, set_flags=1 -> next cycle flags=1001, sticky_v=1, ovf_count=1.
REQ-041 SHALL cover forwarding: subtract, a=b=5, alu_out=0, set_flags=1, cond_valid=1, cond_sel=EQ in the same cycle -> next cycle flags=0110, cond_out_valid=1, cond_true=1; repeating with cond_sel=HI -> cond_true=0.
REQ-042 SHALL cover stall then flush:
- stall=1 with set_flags=1 and cond_valid=1 -> flags and cond outputs unchanged
- flush=1 with cond_valid=1 -> cond_out_valid=0 next cycle
REQ-043 SHALL cover saturation: 260 consecutive overflow events with CNT_W=8 -> ovf_count=255; then clr_sticky=1 with an overflow event in the same cycle -> ovf_count=1, sticky_v=1.
